// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and constants for the clock-switch sequencer.
// Latency/backpressure: n/a (declarations only).
package clk_switch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OFF,
    WAIT_ON,
    DONE,
    ERR
  } state_e;

  localparam logic SEL_CLK_A = 1'b0;
  localparam logic SEL_CLK_B = 1'b1;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Switch-request handshake between system control and the sequencer.
// Latency/backpressure: a request is taken only on a cycle with req_valid & req_ready.
interface clk_switch_ctrl_if;

  logic req_valid;
  logic req_sel;
  logic req_ready;

  modport master (output req_valid, output req_sel, input req_ready);
  modport slave  (input req_valid, input req_sel, output req_ready);

endinterface

// File: rtl/clk_switch_ctrl_sync_bit.sv
// Single-bit STAGES-deep synchronizer, synchronous active-low reset to 0.
// Latency: STAGES clk cycles; no backpressure.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Drives sel of the glitch-free clock switch and confirms each switchover from the gate status bits.
// sel moves 1 cycle after acceptance; req_ready low until done/err. Optional timeout: CLK_SWITCH_CTRL_TIMEOUT_EN.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  clk_switch_ctrl_if.slave   req_if,
  output logic               sel,
  input  logic               gate_a_en,
  input  logic               gate_b_en,
  output logic               cur_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               err_sts
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   cur_sel_q, cur_sel_d;
  logic   err_sts_q, err_sts_d;
  logic   ga_s, gb_s;
  logic   overlap, old_off, new_on;
  logic   ready_c, busy_c, done_c, err_c;
  logic   cnt_clr;
  logic   timeout_hit;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk  (clk),
    .rstn (rstn),
    .d    (gate_a_en),
    .q    (ga_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk  (clk),
    .rstn (rstn),
    .d    (gate_b_en),
    .q    (gb_s)
  );

  assign overlap = ga_s & gb_s;
  // Exit conditions are relative to the target already driven on sel_q.
  assign old_off = (sel_q == SEL_CLK_B) ? ~ga_s : ~gb_s;
  assign new_on  = (sel_q == SEL_CLK_B) ?  gb_s :  ga_s;

`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
  localparam int unsigned      CW      = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]    CNT_MAX = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (busy_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign timeout_hit = (cnt_q == CNT_MAX);
`else
  logic unused_cfg;
  assign unused_cfg  = cnt_clr ^ (^TIMEOUT_CYC);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sel_q     <= SEL_CLK_A;
      cur_sel_q <= SEL_CLK_A;
      err_sts_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cur_sel_q <= cur_sel_d;
      err_sts_q <= err_sts_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cur_sel_d = cur_sel_q;
    err_sts_d = err_sts_q;
    cnt_clr   = 1'b0;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (req_if.req_valid) begin
          err_sts_d = 1'b0;
          if (req_if.req_sel == cur_sel_q) begin
            state_d = DONE;
          end else begin
            sel_d   = req_if.req_sel;
            cnt_clr = 1'b1;
            state_d = WAIT_OFF;
          end
        end
        // Overlap seen while idle is flagged in place; it wins over a same-cycle clear.
        if (overlap) begin
          err_c     = 1'b1;
          err_sts_d = 1'b1;
        end
      end
      WAIT_OFF: begin
        busy_c = 1'b1;
        if (overlap) begin
          state_d = ERR;
        end else if (old_off) begin
          cnt_clr = 1'b1;
          state_d = WAIT_ON;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      WAIT_ON: begin
        busy_c = 1'b1;
        if (overlap) begin
          state_d = ERR;
        end else if (new_on) begin
          cur_sel_d = sel_q;
          state_d   = DONE;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_c     = 1'b1;
        err_sts_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_if.req_ready = ready_c;
  assign sel              = sel_q;
  assign cur_sel          = cur_sel_q;
  assign busy             = busy_c;
  assign done             = done_c;
  assign err              = err_c;
  assign err_sts          = err_sts_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed, table-driven bench for clk_switch_ctrl (SYNC_STAGES=2, TIMEOUT_CYC=8).
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic gate_a_en = 1'b0;
  logic gate_b_en = 1'b0;
  logic sel, cur_sel, busy, done, err, err_sts;

  int n_tests = 0;
  int n_fail  = 0;

  clk_switch_ctrl_if rif ();

  clk_switch_ctrl #(
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_if    (rif),
    .sel       (sel),
    .gate_a_en (gate_a_en),
    .gate_b_en (gate_b_en),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_sts   (err_sts)
  );

  always #5 clk = ~clk;

  // exp = {sel, cur_sel, req_ready, busy, done, err, err_sts}
  typedef struct packed {
    logic       rstn;
    logic       vld;
    logic       rsel;
    logic       ga;
    logic       gb;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic a, input logic b, input logic [6:0] e);
    vec_t t;
    t.rstn = r; t.vld = v; t.rsel = s; t.ga = a; t.gb = b; t.exp = e;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {sel, cur_sel, rif.req_ready, busy, done, err, err_sts};
  endfunction

  initial begin
    int  lat;
    bool_loop: begin end
    rif.req_valid = 1'b0;
    rif.req_sel   = 1'b0;

    // reset, no-op request to A
    tbl.push_back(mk(0,0,0,1,0, 7'b0010000));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010000));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010000));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010000));
    tbl.push_back(mk(1,1,0,1,0, 7'b0000100));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010000));
    // switch to B: gate A drops 3 cycles after sel, gate B rises 3 later
    tbl.push_back(mk(1,1,1,1,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,1,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,1,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,1, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,1, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,1, 7'b1100100));
    tbl.push_back(mk(1,0,0,0,1, 7'b1110000));
    // switch to A while a held request for B waits for req_ready
    tbl.push_back(mk(1,1,0,0,1, 7'b0101000));
    tbl.push_back(mk(1,1,1,0,1, 7'b0101000));
    tbl.push_back(mk(1,1,1,0,0, 7'b0101000));
    tbl.push_back(mk(1,1,1,0,0, 7'b0101000));
    tbl.push_back(mk(1,1,1,1,0, 7'b0101000));
    tbl.push_back(mk(1,1,1,1,0, 7'b0101000));
    tbl.push_back(mk(1,1,1,1,0, 7'b0000100));
    tbl.push_back(mk(1,1,1,1,0, 7'b0010000));
    tbl.push_back(mk(1,1,1,1,0, 7'b1001000));
    // overlap forced during WAIT_ON
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,1,1, 7'b1001000));
    tbl.push_back(mk(1,0,0,1,1, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,1, 7'b1000010));
    tbl.push_back(mk(1,0,0,0,1, 7'b1010001));
    // next accepted request clears err_sts
    tbl.push_back(mk(1,1,1,0,1, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,1, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,1, 7'b1100100));
    tbl.push_back(mk(1,0,0,0,1, 7'b1110000));
    // reset during WAIT_ON toward B
    tbl.push_back(mk(0,0,0,1,0, 7'b0010000));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010000));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010000));
    tbl.push_back(mk(1,1,1,1,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(1,0,0,0,0, 7'b1001000));
    tbl.push_back(mk(0,0,0,0,0, 7'b0010000));
    // overlap while idle, then a no-op request clears err_sts
    tbl.push_back(mk(1,0,0,1,1, 7'b0010000));
    tbl.push_back(mk(1,0,0,1,1, 7'b0010010));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010011));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010001));
    tbl.push_back(mk(1,1,0,1,0, 7'b0000100));
    tbl.push_back(mk(1,0,0,1,0, 7'b0010000));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rstn          = tbl[i].rstn;
      rif.req_valid = tbl[i].vld;
      rif.req_sel   = tbl[i].rsel;
      gate_a_en     = tbl[i].ga;
      gate_b_en     = tbl[i].gb;
      @(posedge clk);
      #1;
      check("vec", i, 32'(outs()), 32'(tbl[i].exp));
    end

    // Switch to B against a behavioural switch model, bounded wait for done.
    begin
      logic busy_drop, err_seen;
      busy_drop = 1'b0;
      err_seen  = 1'b0;
      lat       = 0;
      @(negedge clk);
      rif.req_valid = 1'b1;
      rif.req_sel   = 1'b1;
      @(posedge clk);
      #1;
      check("seq_sel_after_accept", 0, 32'(sel), 32'd1);
      for (int k = 0; k < 30 && lat == 0; k++) begin
        @(negedge clk);
        rif.req_valid = 1'b0;
        gate_a_en     = (k < 3);
        gate_b_en     = (k >= 6);
        @(posedge clk);
        #1;
        if (err) err_seen = 1'b1;
        if (done) begin
          lat = k + 1;
          check("seq_cur_sel_at_done", 0, 32'(cur_sel), 32'd1);
        end else if (!busy) begin
          busy_drop = 1'b1;
        end
      end
      check("seq_done_latency", 0, 32'(lat), 32'd9);
      check("seq_busy_held", 0, 32'(busy_drop), 32'd0);
      check("seq_no_err", 0, 32'(err_seen), 32'd0);
      @(posedge clk);
      #1;
      check("seq_single_done", 0, 32'(done), 32'd0);
      check("seq_ready_back", 0, 32'(rif.req_ready), 32'd1);
    end

`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
    // Gate A stuck on: WAIT_OFF times out after TIMEOUT_CYC cycles.
    @(negedge clk);
    rstn      = 1'b0;
    gate_a_en = 1'b1;
    gate_b_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    rif.req_valid = 1'b1;
    rif.req_sel   = 1'b1;
    @(posedge clk);
    #1;
    check("to_sel_after_accept", 0, 32'(sel), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      rif.req_valid = 1'b0;
      @(posedge clk);
      #1;
      if (err) lat = k;
    end
    check("to_err_cycle", 0, 32'(lat), 32'd8);
    check("to_cur_sel_kept", 0, 32'(cur_sel), 32'd0);
    check("to_sel_kept", 0, 32'(sel), 32'd1);
    @(posedge clk);
    #1;
    check("to_err_sts_set", 0, 32'(err_sts), 32'd1);
    check("to_err_single", 0, 32'(err), 32'd0);
    @(negedge clk);
    rif.req_valid = 1'b1;
    rif.req_sel   = 1'b0;
    @(posedge clk);
    #1;
    check("to_noop_done", 0, 32'(done), 32'd1);
    check("to_err_sts_cleared", 0, 32'(err_sts), 32'd0);
    @(negedge clk);
    rif.req_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
